iic_master_burst: RTL

//  Byte-level I2C master driving the ADXL345 two-wire bus: accepts one register command (device addr, reg ptr, R/W,

---
 rtl/iic_master_burst.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/iic_master_burst.sv
// Byte-level I2C burst master for ADXL345 register access: START, addr, ptr, [Sr, addr+R], data bytes, STOP.
// Optional macro IIC_CLOCK_STRETCH_EN: the SCL-high quarter waits until IIC_SCL_I reads high (slave stretch).
module iic_master_burst #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int IIC_FREQ = 400_000,
    parameter int LEN_W    = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [6:0]       CMD_ADDR,
    input  logic             CMD_RNW,
    input  logic [7:0]       CMD_PTR,
    input  logic [LEN_W-1:0] CMD_LEN,
    input  logic [7:0]       S_DATA,
    input  logic             S_VALID,
    output logic             S_READY,
    output logic [7:0]       M_DATA,
    output logic             M_VALID,
    output logic             BUSY,
    output logic             NACK_ERR,
    input  logic             IIC_SCL_I,
    input  logic             IIC_SDA_I,
    output logic             IIC_SCL_O,
    output logic             IIC_SDA_O
);
    localparam int QTR = CLK_FREQ / (4 * IIC_FREQ);
    localparam int CW  = (QTR > 1) ? $clog2(QTR) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_TX_BYTE, ST_RX_ACK, ST_RSTART, ST_RX_BYTE, ST_TX_ACK, ST_STOP
    } state_t;
    typedef enum logic [1:0] {PH_ADDW, PH_PTR, PH_ADDR_R, PH_DATA} phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        qtr_q, qtr_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d, len_q, len_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        ptr_q, ptr_d;
    logic              rnw_q, rnw_d, need_load_q, need_load_d, ack_q, ack_d;
    logic              scl_q, scl_d, sda_q, sda_d, ready_q, ready_d, busy_q, busy_d;
    logic [7:0]        m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d, s_ready_q, s_ready_d, nack_q, nack_d;
    logic              stretch_s, hold_s, tick_s, bit_end_s, last_s, q2_tick_s;

`ifdef IIC_CLOCK_STRETCH_EN
    assign stretch_s = (state_q != ST_IDLE) && (qtr_q == 2'd2) && !IIC_SCL_I;
`else
    logic scl_unused_s;
    assign scl_unused_s = IIC_SCL_I;
    assign stretch_s    = 1'b0;
`endif

    // A data byte not yet supplied parks the bit engine in Q0, i.e. with SCL low.
    assign hold_s    = ((state_q == ST_TX_BYTE) && need_load_q) || stretch_s;
    assign tick_s    = (state_q != ST_IDLE) && !hold_s && (cnt_q == CW'(QTR - 1));
    assign q2_tick_s = tick_s && (qtr_q == 2'd2);
    assign bit_end_s = tick_s && (qtr_q == 2'd3);
    assign last_s    = ((byte_cnt_q + LEN_W'(1)) == len_q);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;  phase_d = phase_q;  bit_d = bit_q;  shift_d = shift_q;
        byte_cnt_d = byte_cnt_q;  len_d = len_q;  addr_d = addr_q;  ptr_d = ptr_q;
        rnw_d = rnw_q;  need_load_d = need_load_q;  ack_d = ack_q;  m_data_d = m_data_q;
        m_valid_d = 1'b0;  s_ready_d = 1'b0;  nack_d = 1'b0;
        scl_d = 1'b1;  sda_d = 1'b1;
        if ((state_q == ST_IDLE) || tick_s) begin
            cnt_d = {CW{1'b0}};
        end else if (hold_s) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        qtr_d = tick_s ? (qtr_q + 2'd1) : qtr_q;
        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    state_d    = ST_START;
                    phase_d    = PH_ADDW;
                    addr_d     = CMD_ADDR;
                    rnw_d      = CMD_RNW;
                    ptr_d      = CMD_PTR;
                    len_d      = (CMD_LEN == {LEN_W{1'b0}}) ? LEN_W'(1) : CMD_LEN;
                    shift_d    = {CMD_ADDR, 1'b0};
                    bit_d      = 3'd0;
                    byte_cnt_d = {LEN_W{1'b0}};
                    qtr_d      = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = bit_end_s ? ST_TX_BYTE : ST_START;
            end
            ST_TX_BYTE: begin
                if (need_load_q && S_VALID) begin
                    shift_d     = S_DATA;
                    s_ready_d   = 1'b1;
                    need_load_d = 1'b0;
                end else if (bit_end_s) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? ST_RX_ACK : ST_TX_BYTE;
                end else begin
                    state_d = ST_TX_BYTE;
                end
            end
            ST_RX_ACK: begin
                if (q2_tick_s) begin
                    ack_d = IIC_SDA_I;
                end else if (bit_end_s && ack_q) begin
                    nack_d  = 1'b1;
                    state_d = ST_STOP;
                end else if (bit_end_s) begin
                    case (phase_q)
                        PH_ADDW: begin
                            state_d = ST_TX_BYTE;
                            phase_d = PH_PTR;
                            shift_d = ptr_q;
                        end
                        PH_PTR: begin
                            state_d     = rnw_q ? ST_RSTART : ST_TX_BYTE;
                            phase_d     = PH_DATA;
                            need_load_d = !rnw_q;
                        end
                        PH_ADDR_R: begin
                            state_d = ST_RX_BYTE;
                            phase_d = PH_DATA;
                        end
                        default: begin
                            byte_cnt_d  = byte_cnt_q + LEN_W'(1);
                            state_d     = last_s ? ST_STOP : ST_TX_BYTE;
                            need_load_d = !last_s;
                        end
                    endcase
                end else begin
                    state_d = ST_RX_ACK;
                end
            end
            ST_RSTART: begin
                if (bit_end_s) begin
                    state_d = ST_TX_BYTE;
                    phase_d = PH_ADDR_R;
                    shift_d = {addr_q, 1'b1};
                end else begin
                    state_d = ST_RSTART;
                end
            end
            ST_RX_BYTE: begin
                if (q2_tick_s) begin
                    shift_d   = {shift_q[6:0], IIC_SDA_I};
                    m_valid_d = (bit_q == 3'd7);
                    m_data_d  = (bit_q == 3'd7) ? {shift_q[6:0], IIC_SDA_I} : m_data_q;
                end else if (bit_end_s) begin
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? ST_TX_ACK : ST_RX_BYTE;
                end else begin
                    state_d = ST_RX_BYTE;
                end
            end
            ST_TX_ACK: begin
                if (bit_end_s) begin
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    state_d    = last_s ? ST_STOP : ST_RX_BYTE;
                end else begin
                    state_d = ST_TX_ACK;
                end
            end
            ST_STOP: begin
                state_d = bit_end_s ? ST_IDLE : ST_STOP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Line levels follow the state/quarter being entered so the pins are registered.
        case (state_d)
            ST_IDLE:    begin scl_d = 1'b1;     sda_d = 1'b1;                 end
            ST_START:   begin scl_d = 1'b1;     sda_d = (qtr_d != 2'd3);      end
            ST_RSTART:  begin scl_d = qtr_d[1]; sda_d = (qtr_d != 2'd3);      end
            ST_STOP:    begin scl_d = qtr_d[1]; sda_d = (qtr_d == 2'd3);      end
            ST_TX_BYTE: begin scl_d = qtr_d[1]; sda_d = shift_d[7];           end
            ST_TX_ACK:  begin scl_d = qtr_d[1]; sda_d = last_s;               end
            default:    begin scl_d = qtr_d[1]; sda_d = 1'b1;                 end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;  phase_q <= PH_ADDW;  cnt_q <= {CW{1'b0}};  qtr_q <= 2'd0;
            bit_q <= 3'd0;  shift_q <= 8'd0;  byte_cnt_q <= {LEN_W{1'b0}};  len_q <= LEN_W'(1);
            addr_q <= 7'd0;  ptr_q <= 8'd0;  rnw_q <= 1'b0;  need_load_q <= 1'b0;  ack_q <= 1'b0;
            scl_q <= 1'b1;  sda_q <= 1'b1;  ready_q <= 1'b1;  busy_q <= 1'b0;
            m_data_q <= 8'd0;  m_valid_q <= 1'b0;  s_ready_q <= 1'b0;  nack_q <= 1'b0;
        end else begin
            state_q <= state_d;  phase_q <= phase_d;  cnt_q <= cnt_d;  qtr_q <= qtr_d;
            bit_q <= bit_d;  shift_q <= shift_d;  byte_cnt_q <= byte_cnt_d;  len_q <= len_d;
            addr_q <= addr_d;  ptr_q <= ptr_d;  rnw_q <= rnw_d;  need_load_q <= need_load_d;  ack_q <= ack_d;
            scl_q <= scl_d;  sda_q <= sda_d;  ready_q <= ready_d;  busy_q <= busy_d;
            m_data_q <= m_data_d;  m_valid_q <= m_valid_d;  s_ready_q <= s_ready_d;  nack_q <= nack_d;
        end
    end

    assign CMD_READY = ready_q;
    assign BUSY      = busy_q;
    assign S_READY   = s_ready_q;
    assign M_DATA    = m_data_q;
    assign M_VALID   = m_valid_q;
    assign NACK_ERR  = nack_q;
    assign IIC_SCL_O = scl_q;
    assign IIC_SDA_O = sda_q;
endmodule
